dmem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port data memory (combinational read, clocked write, word addressed) between the RISC-V core's load/store port (requester 0) and a second bus master such as a loader or debug port (requester 1). It sits between the requesters and `dmem`. It serialises accesses through a registered ownership state machine, caps back-to-back bursts so neither side starves, and returns registered responses.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/arb_rsp_reg.sv | 33 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership states and requester IDs.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

endpackage

// File: rtl/arb_rsp_reg.sv
// Per-requester response register: one-cycle strobe after an accept, load data captured
// in the accept cycle (zero for stores) and held until the next response.
module arb_rsp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] rd_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o
);

  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= accept_i;
      if (accept_i) begin
        rdata_q <= we_i ? '0 : rd_i;
      end
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one dmem port between the core (0) and an aux master (1).
// Ready follows valid while owner; IDLE costs one cycle; responses are registered (+1 cycle).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata0,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_next;
  logic [1:0]       accept;
  logic             own_id, own_vld, other_vld, burst_done;

  assign own_id    = (state_q == OWN1);
  assign own_vld   = req_valid[own_id];
  assign other_vld = req_valid[~own_id];

  // Reset gates the handshake combinationally so nothing is written in the reset cycle.
  always_comb begin
    accept = 2'b00;
    if (!reset) begin
      case (state_q)
        OWN0:    accept[REQ_CPU] = req_valid[REQ_CPU];
        OWN1:    accept[REQ_AUX] = req_valid[REQ_AUX];
        default: accept = 2'b00;
      endcase
    end
  end

  assign req_ready = accept;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (accept[REQ_CPU]) begin
      mem_we   = req_we[REQ_CPU];
      mem_addr = req_addr0;
      mem_wd   = req_wdata0;
    end else if (accept[REQ_AUX]) begin
      mem_we   = req_we[REQ_AUX];
      mem_addr = req_addr1;
      mem_wd   = req_wdata1;
    end
  end

  // Compared with >= so a saturated counter still yields to a newly arriving requester.
  assign cnt_next   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, |accept};
  assign burst_done = (cnt_next >= BURST_LIM);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid == 2'b11) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req_valid[REQ_CPU]) begin
          state_d = OWN0;
        end else if (req_valid[REQ_AUX]) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (|accept) begin
          last_d = own_id;
        end
        if (!own_vld || (burst_done && other_vld)) begin
          state_d = other_vld ? (own_id ? OWN0 : OWN1) : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = burst_done ? BURST_LIM[CNT_W-1:0] : cnt_next[CNT_W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  arb_rsp_reg #(.DATA_W(DATA_W)) u_rsp0 (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (accept[REQ_CPU]),
    .we_i        (req_we[REQ_CPU]),
    .rd_i        (mem_rd),
    .rsp_valid_o (rsp_valid[REQ_CPU]),
    .rsp_rdata_o (rsp_rdata0)
  );

  arb_rsp_reg #(.DATA_W(DATA_W)) u_rsp1 (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (accept[REQ_AUX]),
    .we_i        (req_we[REQ_AUX]),
    .rd_i        (mem_rd),
    .rsp_valid_o (rsp_valid[REQ_AUX]),
    .rsp_rdata_o (rsp_rdata1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural dmem, reference memory and per-requester response queues.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  logic        mem_init_done = 1'b0;
  logic        ref_init      = 1'b0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] mon_exp;
  logic [64:0] mon_bus;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata0 (rsp_rdata0),
    .rsp_rdata1 (rsp_rdata1),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 22) return 32'h0000_1234;   // 0x58
    if (i == 24) return 32'h0000_0005;   // 0x60
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // dmem: combinational read, clocked write, word addressed
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[9:2]] <= mem_wd;
    end
  end
  assign mem_rd = dmem[mem_addr[9:2]];

  // Scoreboard: check responses against queued expectations, check the memory bus
  // against the accepted requester's payload, then queue expectations for new accepts.
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (rsp_valid[0]) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL rsp0_unexpected: rsp_valid[0]=1 with no accepted request");
      end else begin
        mon_exp = q0.pop_front();
        if (rsp_rdata0 !== mon_exp) begin
          n_err++;
          $display("FAIL rsp0_data: got %h expected %h", rsp_rdata0, mon_exp);
        end
      end
    end
    if (rsp_valid[1]) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL rsp1_unexpected: rsp_valid[1]=1 with no accepted request");
      end else begin
        mon_exp = q1.pop_front();
        if (rsp_rdata1 !== mon_exp) begin
          n_err++;
          $display("FAIL rsp1_data: got %h expected %h", rsp_rdata1, mon_exp);
        end
      end
    end
    mon_bus = '0;
    if (req_ready == 2'b01) mon_bus = {req_we[0], req_addr0, req_wdata0};
    if (req_ready == 2'b10) mon_bus = {req_we[1], req_addr1, req_wdata1};
    n_cmp++;
    if ({mem_we, mem_addr, mem_wd} !== mon_bus) begin
      n_err++;
      $display("FAIL mem_bus: got %h expected %h (ready=%b)", {mem_we, mem_addr, mem_wd}, mon_bus, req_ready);
    end
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req_ready[0]) begin
        q0.push_back(req_we[0] ? 32'h0 : ref_mem[req_addr0[9:2]]);
        if (req_we[0]) ref_mem[req_addr0[9:2]] = req_wdata0;
      end
      if (req_ready[1]) begin
        q1.push_back(req_we[1] ? 32'h0 : ref_mem[req_addr1[9:2]]);
        if (req_we[1]) ref_mem[req_addr1[9:2]] = req_wdata1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input logic [1:0] exp, input string name);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== exp) begin
      n_err++;
      $display("FAIL %s: req_ready got %b expected %b", name, req_ready, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; req_we = 2'b11;
    req_addr0 = 32'h10; req_wdata0 = 32'hAAAA_0001;
    req_addr1 = 32'h20; req_wdata1 = 32'hBBBB_0002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: ready=%b mem_we=%b expected 00/0", req_ready, mem_we);
      end
      n_cmp++;
      if ({rsp_valid, rsp_rdata0, rsp_rdata1, mem_addr, mem_wd} !== '0) begin
        n_err++;
        $display("FAIL reset_values: rsp_valid=%b rd0=%h rd1=%h addr=%h wd=%h expected all 0",
                 rsp_valid, rsp_rdata0, rsp_rdata1, mem_addr, mem_wd);
      end
      next_cycle();
    end
    reset = 1'b0;
    chk_ready(2'b00, "reset_release_idle");
    n_cmp++;
    if (dmem[4] !== init_val(4) || dmem[8] !== init_val(8)) begin
      n_err++;
      $display("FAIL reset_no_write: dmem[0x10]=%h dmem[0x20]=%h expected %h %h",
               dmem[4], dmem[8], init_val(4), init_val(8));
    end
    next_cycle();
    chk_ready(2'b01, "reset_first_grant");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b01 || rsp_rdata0 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_store_ack: rsp_valid=%b rd0=%h expected 01/0", rsp_valid, rsp_rdata0);
    end
    next_cycle();
  endtask

  task automatic test_single_load();
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h60;
    chk_ready(2'b00, "load_idle_cycle");
    next_cycle();
    chk_ready(2'b01, "load_ready");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b01 || rsp_rdata0 !== 32'h5) begin
      n_err++;
      $display("FAIL load_rsp: rsp_valid=%b rd0=%h expected 01/00000005", rsp_valid, rsp_rdata0);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_rdata0 !== 32'h5) begin
      n_err++;
      $display("FAIL load_hold: rsp_valid=%b rd0=%h expected 00/00000005", rsp_valid, rsp_rdata0);
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = 32'h64; req_wdata1 = 32'h3FFF;
    chk_ready(2'b00, "st_idle_cycle");
    next_cycle();
    chk_ready(2'b10, "st_ready");
    next_cycle();
    req_we = 2'b00;
    chk_ready(2'b10, "ld_same_cycle_ready");
    n_cmp++;
    if (rsp_valid !== 2'b10 || rsp_rdata1 !== 32'h0) begin
      n_err++;
      $display("FAIL st_ack: rsp_valid=%b rd1=%h expected 10/0", rsp_valid, rsp_rdata1);
    end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b10 || rsp_rdata1 !== 32'h3FFF) begin
      n_err++;
      $display("FAIL ld_after_st: rsp_valid=%b rd1=%h expected 10/00003fff", rsp_valid, rsp_rdata1);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] prev, exp;
    req_valid = 2'b11; req_we = 2'b10;
    req_addr0 = 32'h100; req_addr1 = 32'h200; req_wdata1 = 32'hB000_0000;
    chk_ready(2'b00, "cont_idle_cycle");
    prev = req_ready;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (prev[0]) req_addr0 = req_addr0 + 32'd4;
      if (prev[1]) begin
        req_addr1  = req_addr1 + 32'd4;
        req_wdata1 = req_wdata1 + 32'd1;
      end
      exp = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== exp) begin
        n_err++;
        $display("FAIL cont_grant[%0d]: req_ready got %b expected %b", i, req_ready, exp);
      end
      prev = req_ready;
    end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_dropout();
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h60;
    chk_ready(2'b00, "drop_idle_cycle");
    next_cycle();
    chk_ready(2'b01, "drop_own0_a");
    next_cycle();
    chk_ready(2'b01, "drop_own0_b");
    next_cycle();
    req_valid = 2'b00;
    chk_ready(2'b00, "drop_released");
    next_cycle();
    req_valid = 2'b10; req_addr1 = 32'h64;
    chk_ready(2'b00, "drop_req1_idle");
    next_cycle();
    chk_ready(2'b10, "drop_req1_ready");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    next_cycle();
    req_valid = 2'b01;
    chk_ready(2'b00, "drop_re0_idle");
    next_cycle();
    chk_ready(2'b01, "drop_re0_own");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    next_cycle();
    req_valid = 2'b01;
    chk_ready(2'b00, "drop_re0_back_to_idle");
    next_cycle();
    chk_ready(2'b01, "drop_re0_regrant");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_reset_midburst();
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = 32'h58; req_wdata1 = 32'hDEAD_BEEF;
    chk_ready(2'b00, "rmb_idle_cycle");
    next_cycle();
    reset = 1'b1;
    chk_ready(2'b00, "rmb_ready_forced");
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rmb_mem_we: got %b expected 0", mem_we);
    end
    next_cycle();
    reset = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, mem_we, mem_addr, mem_wd} !== '0) begin
      n_err++;
      $display("FAIL rmb_outputs: ready=%b rsp=%b rd0=%h rd1=%h we=%b addr=%h wd=%h expected all 0",
               req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, mem_we, mem_addr, mem_wd);
    end
    n_cmp++;
    if (dmem[22] !== 32'h1234) begin
      n_err++;
      $display("FAIL rmb_no_write: dmem[0x58] got %h expected 00001234", dmem[22]);
    end
    next_cycle();
    req_valid = 2'b10; req_we = 2'b00;
    chk_ready(2'b00, "rmb_state_idle");
    next_cycle();
    chk_ready(2'b10, "rmb_regrant");
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b10 || rsp_rdata1 !== 32'h1234) begin
      n_err++;
      $display("FAIL rmb_readback: rsp_valid=%b rd1=%h expected 10/00001234", rsp_valid, rsp_rdata1);
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    test_reset();
    test_single_load();
    test_store_load();
    test_contention();
    test_dropout();
    test_reset_midburst();
    for (int i = 0; i < 3; i++) next_cycle();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL rsp_missing: pending q0=%0d q1=%0d expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
